// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/stall controller.
// The master side is the datapath and the slave side is hazard_ctrl.
interface hazard_ctrl_if;
    logic        id_valid;
    logic [2:0]  id_Rs;
    logic [2:0]  id_Rt;
    logic        id_has_Rs;
    logic        id_has_Rt;
    logic        id_halt;
    logic        ex_wr_en;
    logic [2:0]  ex_Rd;
    logic        ex_mem_rd;
    logic        mem_wr_en;
    logic [2:0]  mem_Rd;
    logic        ex_branch_taken;
    logic        mem_busy;

    logic        pc_wr_en;
    logic        if_id_wr_en;
    logic        id_ex_wr_en;
    logic        ex_mem_wr_en;
    logic        id_ex_bubble;
    logic        flush_if_id;
    logic        mem_wb_bubble;
    logic        halted;
    logic [15:0] stall_cycles;

    modport master (
        output id_valid, id_Rs, id_Rt, id_has_Rs, id_has_Rt, id_halt,
               ex_wr_en, ex_Rd, ex_mem_rd, mem_wr_en, mem_Rd,
               ex_branch_taken, mem_busy,
        input  pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en,
               id_ex_bubble, flush_if_id, mem_wb_bubble, halted, stall_cycles
    );

    modport slave (
        input  id_valid, id_Rs, id_Rt, id_has_Rs, id_has_Rt, id_halt,
               ex_wr_en, ex_Rd, ex_mem_rd, mem_wr_en, mem_Rd,
               ex_branch_taken, mem_busy,
        output pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en,
               id_ex_bubble, flush_if_id, mem_wb_bubble, halted, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: freeze, flush, data stall, halt drain.
// Define FORWARD_EN when the forwarding unit is present (load-use stalls only).
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input logic        clk,
    input logic        rst,
    hazard_ctrl_if.slave hz
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic [15:0]   stall_cycles_q, stall_cycles_d;

    logic pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en;
    logic id_ex_bubble, flush_if_id, mem_wb_bubble, halted;
    logic rs_ex_match, rt_ex_match, data_stall;

    assign rs_ex_match = hz.id_valid & hz.id_has_Rs & hz.ex_wr_en & (hz.id_Rs == hz.ex_Rd);
    assign rt_ex_match = hz.id_valid & hz.id_has_Rt & hz.ex_wr_en & (hz.id_Rt == hz.ex_Rd);

`ifdef FORWARD_EN
    // Forwarding covers everything except a load whose data is not yet read.
    assign data_stall = hz.ex_mem_rd & (rs_ex_match | rt_ex_match);
`else
    logic rs_mem_match, rt_mem_match;
    assign rs_mem_match = hz.id_valid & hz.id_has_Rs & hz.mem_wr_en & (hz.id_Rs == hz.mem_Rd);
    assign rt_mem_match = hz.id_valid & hz.id_has_Rt & hz.mem_wr_en & (hz.id_Rt == hz.mem_Rd);
    assign data_stall   = rs_ex_match | rt_ex_match | rs_mem_match | rt_mem_match;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            drain_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        stall_cycles_d = stall_cycles_q;
        pc_wr_en       = 1'b1;
        if_id_wr_en    = 1'b1;
        id_ex_wr_en    = 1'b1;
        ex_mem_wr_en   = 1'b1;
        id_ex_bubble   = 1'b0;
        flush_if_id    = 1'b0;
        mem_wb_bubble  = 1'b0;
        halted         = 1'b0;

        // While in reset the pipeline free-runs so NOPs flush through.
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (hz.mem_busy) begin
                        pc_wr_en      = 1'b0;
                        if_id_wr_en   = 1'b0;
                        id_ex_wr_en   = 1'b0;
                        ex_mem_wr_en  = 1'b0;
                        mem_wb_bubble = 1'b1;
                    end else if (hz.ex_branch_taken) begin
                        flush_if_id  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (data_stall) begin
                        pc_wr_en     = 1'b0;
                        if_id_wr_en  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (hz.id_valid && hz.id_halt) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_INIT;
                    end
                    if (!pc_wr_en && stall_cycles_q != 16'hFFFF)
                        stall_cycles_d = stall_cycles_q + 16'd1;
                end
                DRAIN: begin
                    pc_wr_en = 1'b0;
                    if (hz.mem_busy) begin
                        if_id_wr_en   = 1'b0;
                        id_ex_wr_en   = 1'b0;
                        ex_mem_wr_en  = 1'b0;
                        mem_wb_bubble = 1'b1;
                    end else begin
                        flush_if_id = 1'b1;
                        // HALT retires on the edge where the count hits zero.
                        if (drain_cnt_q <= CW'(1))
                            state_d = HALTED;
                        if (drain_cnt_q != '0)
                            drain_cnt_d = drain_cnt_q - CW'(1);
                    end
                end
                HALTED: begin
                    pc_wr_en     = 1'b0;
                    if_id_wr_en  = 1'b0;
                    id_ex_wr_en  = 1'b0;
                    ex_mem_wr_en = 1'b0;
                    halted       = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign hz.pc_wr_en      = pc_wr_en;
    assign hz.if_id_wr_en   = if_id_wr_en;
    assign hz.id_ex_wr_en   = id_ex_wr_en;
    assign hz.ex_mem_wr_en  = ex_mem_wr_en;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.flush_if_id   = flush_if_id;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.halted        = halted;
    assign hz.stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow the FORWARD_EN setting.
module tb_hazard_ctrl;

    localparam logic [7:0] ADV     = 8'b1111_0000;
    localparam logic [7:0] DSTALL  = 8'b0011_1000;
    localparam logic [7:0] FREEZE  = 8'b0000_0010;
    localparam logic [7:0] FLUSH   = 8'b1111_1100;
    localparam logic [7:0] DRAINV  = 8'b0111_0100;
    localparam logic [7:0] HALTEDV = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    hazard_ctrl_if hz_if ();

    hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    always #5 clk = ~clk;

    // Order: pc, if_id, id_ex, ex_mem, id_ex_bubble, flush_if_id, mem_wb_bubble, halted.
    wire [7:0] ctl = {hz_if.pc_wr_en, hz_if.if_id_wr_en, hz_if.id_ex_wr_en, hz_if.ex_mem_wr_en,
                      hz_if.id_ex_bubble, hz_if.flush_if_id, hz_if.mem_wb_bubble, hz_if.halted};

    task automatic clear_inputs;
        hz_if.id_valid = 0; hz_if.id_Rs = 0; hz_if.id_Rt = 0;
        hz_if.id_has_Rs = 0; hz_if.id_has_Rt = 0; hz_if.id_halt = 0;
        hz_if.ex_wr_en = 0; hz_if.ex_Rd = 0; hz_if.ex_mem_rd = 0;
        hz_if.mem_wr_en = 0; hz_if.mem_Rd = 0;
        hz_if.ex_branch_taken = 0; hz_if.mem_busy = 0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1;
        clear_inputs();
        tick();
        rst = 0;
    endtask

    task automatic set_load_use;
        hz_if.id_valid = 1; hz_if.id_Rs = 3'd3; hz_if.id_has_Rs = 1;
        hz_if.ex_wr_en = 1; hz_if.ex_Rd = 3'd3; hz_if.ex_mem_rd = 1;
    endtask

    task automatic test_reset;
        rst = 1;
        clear_inputs();
        set_load_use();
        hz_if.mem_busy = 1;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL reset_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        tick();
        total++;
        if (hz_if.stall_cycles !== 16'd0) begin
            $display("FAIL reset_stall actual=%0d required=0", hz_if.stall_cycles); bad++;
        end
        rst = 0;
        clear_inputs();
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL reset_idle_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
    endtask

    task automatic test_data_hazard;
        do_reset();
`ifdef FORWARD_EN
        set_load_use();
        #1;
        total++;
        if (ctl !== DSTALL) begin
            $display("FAIL load_use_ctl actual=%b required=%b", ctl, DSTALL); bad++;
        end
        tick();
        total++;
        if (hz_if.stall_cycles !== 16'd1) begin
            $display("FAIL load_use_count actual=%0d required=1", hz_if.stall_cycles); bad++;
        end
        hz_if.ex_wr_en = 0; hz_if.ex_mem_rd = 0; hz_if.ex_Rd = 0;
        hz_if.mem_wr_en = 1; hz_if.mem_Rd = 3'd3;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL load_in_mem_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        clear_inputs();
        hz_if.id_valid = 1; hz_if.id_Rt = 3'd5; hz_if.id_has_Rt = 1;
        hz_if.ex_wr_en = 1; hz_if.ex_Rd = 3'd5;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL alu_forward_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        tick();
        total++;
        if (hz_if.stall_cycles !== 16'd1) begin
            $display("FAIL alu_forward_count actual=%0d required=1", hz_if.stall_cycles); bad++;
        end
`else
        hz_if.id_valid = 1; hz_if.id_Rt = 3'd5; hz_if.id_has_Rt = 1;
        hz_if.ex_wr_en = 1; hz_if.ex_Rd = 3'd5;
        #1;
        total++;
        if (ctl !== DSTALL) begin
            $display("FAIL raw_ex_ctl actual=%b required=%b", ctl, DSTALL); bad++;
        end
        tick();
        hz_if.ex_wr_en = 0; hz_if.ex_Rd = 0;
        hz_if.mem_wr_en = 1; hz_if.mem_Rd = 3'd5;
        #1;
        total++;
        if (ctl !== DSTALL) begin
            $display("FAIL raw_mem_ctl actual=%b required=%b", ctl, DSTALL); bad++;
        end
        tick();
        hz_if.mem_wr_en = 0; hz_if.mem_Rd = 0;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL raw_clear_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        total++;
        if (hz_if.stall_cycles !== 16'd2) begin
            $display("FAIL raw_count actual=%0d required=2", hz_if.stall_cycles); bad++;
        end
`endif
        clear_inputs();
        hz_if.id_valid = 1; hz_if.id_Rs = 3'd2; hz_if.id_has_Rs = 0;
        hz_if.ex_wr_en = 1; hz_if.ex_Rd = 3'd2; hz_if.ex_mem_rd = 1;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL unused_src_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        hz_if.id_has_Rs = 1; hz_if.id_valid = 0;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL invalid_id_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        hz_if.id_valid = 1; hz_if.ex_Rd = 3'd6;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL reg_mismatch_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
    endtask

    task automatic test_flush;
        do_reset();
        set_load_use();
        hz_if.id_halt = 1;
        hz_if.ex_branch_taken = 1;
        #1;
        total++;
        if (ctl !== FLUSH) begin
            $display("FAIL flush_ctl actual=%b required=%b", ctl, FLUSH); bad++;
        end
        tick();
        total++;
        if (hz_if.stall_cycles !== 16'd0) begin
            $display("FAIL flush_count actual=%0d required=0", hz_if.stall_cycles); bad++;
        end
        clear_inputs();
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL flush_halt_ignored actual=%b required=%b", ctl, ADV); bad++;
        end
    endtask

    task automatic test_freeze;
        do_reset();
        set_load_use();
        hz_if.mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (ctl !== FREEZE) begin
                $display("FAIL freeze_ctl_%0d actual=%b required=%b", i, ctl, FREEZE); bad++;
            end
            tick();
        end
        hz_if.mem_busy = 0;
        #1;
        total++;
        if (ctl !== DSTALL) begin
            $display("FAIL freeze_then_stall actual=%b required=%b", ctl, DSTALL); bad++;
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL freeze_resume actual=%b required=%b", ctl, ADV); bad++;
        end
        total++;
        if (hz_if.stall_cycles !== 16'd5) begin
            $display("FAIL freeze_count actual=%0d required=5", hz_if.stall_cycles); bad++;
        end
    endtask

    task automatic test_halt_drain;
        do_reset();
        hz_if.id_valid = 1; hz_if.id_halt = 1;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL halt_accept_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        tick();
        clear_inputs();
        hz_if.ex_branch_taken = 1;
        #1;
        total++;
        if (ctl !== DRAINV) begin
            $display("FAIL drain1_ctl actual=%b required=%b", ctl, DRAINV); bad++;
        end
        tick();
        hz_if.ex_branch_taken = 0;
        hz_if.mem_busy = 1;
        #1;
        total++;
        if (ctl !== FREEZE) begin
            $display("FAIL drain_freeze_ctl actual=%b required=%b", ctl, FREEZE); bad++;
        end
        tick();
        hz_if.mem_busy = 0;
        #1;
        total++;
        if (ctl !== DRAINV) begin
            $display("FAIL drain_last_ctl actual=%b required=%b", ctl, DRAINV); bad++;
        end
        tick();
        total++;
        if (ctl !== HALTEDV) begin
            $display("FAIL halted_ctl actual=%b required=%b", ctl, HALTEDV); bad++;
        end
        hz_if.id_valid = 1; hz_if.ex_branch_taken = 1;
        tick();
        tick();
        total++;
        if (ctl !== HALTEDV) begin
            $display("FAIL halted_sticky actual=%b required=%b", ctl, HALTEDV); bad++;
        end
        total++;
        if (hz_if.stall_cycles !== 16'd0) begin
            $display("FAIL halt_count actual=%0d required=0", hz_if.stall_cycles); bad++;
        end
        rst = 1;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL halted_rst_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        tick();
        rst = 0;
        clear_inputs();
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL halted_rst_run actual=%b required=%b", ctl, ADV); bad++;
        end
    endtask

    task automatic test_reset_mid_drain;
        do_reset();
        hz_if.id_valid = 1; hz_if.id_halt = 1;
        tick();
        clear_inputs();
        rst = 1;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL mid_drain_rst_ctl actual=%b required=%b", ctl, ADV); bad++;
        end
        tick();
        rst = 0;
        #1;
        total++;
        if (ctl !== ADV) begin
            $display("FAIL mid_drain_run actual=%b required=%b", ctl, ADV); bad++;
        end
    endtask

    task automatic test_saturation;
        do_reset();
        hz_if.mem_busy = 1;
        for (int i = 0; i < 65534; i++) tick();
        total++;
        if (hz_if.stall_cycles !== 16'hFFFE) begin
            $display("FAIL sat_pre actual=%h required=fffe", hz_if.stall_cycles); bad++;
        end
        tick();
        total++;
        if (hz_if.stall_cycles !== 16'hFFFF) begin
            $display("FAIL sat_reach actual=%h required=ffff", hz_if.stall_cycles); bad++;
        end
        hz_if.mem_busy = 0;
        set_load_use();
        hz_if.ex_wr_en = 1; hz_if.mem_wr_en = 1; hz_if.mem_Rd = 3'd3;
        tick();
        tick();
        hz_if.mem_busy = 1;
        tick();
        total++;
        if (hz_if.stall_cycles !== 16'hFFFF) begin
            $display("FAIL sat_hold actual=%h required=ffff", hz_if.stall_cycles); bad++;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_data_hazard();
        test_flush();
        test_freeze();
        test_halt_drain();
        test_reset_mid_drain();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
